// File: rtl/alog_frame_tx.sv
// alog_frame_tx: buffers (ch2, ch3, ref) sample triplets in a small FIFO and
// presents one triplet per frame to the adaptive filter, framed by head_flag.
// Optional build macro: ALOG_TX_STATS_EN adds frame_cnt / underrun_cnt outputs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tx_en               start frames when data is available (sampled in IDLE)
//   in_valid, in_ready  upstream triplet handshake (in_ready = FIFO not full)
//   in_ch2/ch3/ref      incoming samples
//   buffer_2/3, reff    registered samples to the filter
//   head_flag           registered frame strobe
//   busy                frame or gap in progress
//   underrun            1-cycle pulse: gap ended with tx_en=1 and FIFO empty
module alog_frame_tx #(
   parameter int DW        = 14,
   parameter int DEPTH     = 4,
   parameter int FRAME_LEN = 52,
   parameter int GAP_LEN   = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tx_en,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_ch2,
   input  logic [DW-1:0] in_ch3,
   input  logic [DW-1:0] in_ref,
   output logic [DW-1:0] buffer_2,
   output logic [DW-1:0] buffer_3,
   output logic [DW-1:0] reff,
   output logic          head_flag,
   output logic          busy,
   output logic          underrun
`ifdef ALOG_TX_STATS_EN
   ,
   output logic [15:0]   frame_cnt,
   output logic [15:0]   underrun_cnt
`endif
);

   localparam int AW   = $clog2(DEPTH);
   localparam int MAXL = (FRAME_LEN > GAP_LEN) ? FRAME_LEN : GAP_LEN;
   localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

   localparam logic [CW-1:0] HEAD_LAST = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, HEAD, GAP} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [3*DW-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     fifo_cnt;
   logic            push;
   logic            pop;
   logic            empty;

   assign in_ready = (fifo_cnt != FULL_CNT);
   assign empty    = (fifo_cnt == '0);
   assign push     = in_valid & in_ready;
   assign pop      = (state == IDLE) & tx_en & ~empty;
   assign busy     = (state != IDLE);

   // Storage has no reset; emptiness is defined by the pointers/count.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {in_ch2, in_ch3, in_ref};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            fifo_cnt <= fifo_cnt + 1'b1;
         else if (pop && !push)
            fifo_cnt <= fifo_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         head_flag <= 1'b0;
         buffer_2  <= '0;
         buffer_3  <= '0;
         reff      <= '0;
         underrun  <= 1'b0;
      end else begin
         underrun <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  {buffer_2, buffer_3, reff} <= mem[rd_ptr];
                  head_flag <= 1'b1;
                  cnt       <= '0;
                  state     <= HEAD;
               end
            end
            HEAD: begin
               if (cnt == HEAD_LAST) begin
                  head_flag <= 1'b0;
                  cnt       <= '0;
                  state     <= GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt      <= '0;
                  state    <= IDLE;
                  // FIFO state before this edge decides the underrun.
                  underrun <= tx_en & empty;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               head_flag <= 1'b0;
               cnt       <= '0;
            end
         endcase
      end
   end

`ifdef ALOG_TX_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt    <= '0;
         underrun_cnt <= '0;
      end else begin
         if (pop && frame_cnt != 16'hFFFF)
            frame_cnt <= frame_cnt + 1'b1;
         if (underrun && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_alog_frame_tx.sv
// tb_alog_frame_tx: self-checking bench for alog_frame_tx
// (reset, single frame, back-to-back, full FIFO, tx_en drop, stats).
module tb_alog_frame_tx;

   localparam int DW = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tx_en = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_ch2 = '0;
   logic [DW-1:0] in_ch3 = '0;
   logic [DW-1:0] in_ref = '0;
   logic [DW-1:0] buffer_2;
   logic [DW-1:0] buffer_3;
   logic [DW-1:0] reff;
   logic          head_flag;
   logic          busy;
   logic          underrun;
`ifdef ALOG_TX_STATS_EN
   logic [15:0]   frame_cnt;
   logic [15:0]   underrun_cnt;
`endif

   always #5 clk = ~clk;

   alog_frame_tx dut (
      .clk       (clk),
      .rst       (rst),
      .tx_en     (tx_en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ch2    (in_ch2),
      .in_ch3    (in_ch3),
      .in_ref    (in_ref),
      .buffer_2  (buffer_2),
      .buffer_3  (buffer_3),
      .reff      (reff),
      .head_flag (head_flag),
      .busy      (busy),
      .underrun  (underrun)
`ifdef ALOG_TX_STATS_EN
      ,
      .frame_cnt    (frame_cnt),
      .underrun_cnt (underrun_cnt)
`endif
   );

   typedef struct {
      logic [DW-1:0] c2;
      logic [DW-1:0] c3;
      logic [DW-1:0] r;
   } trip_t;

   typedef struct {
      logic          v;
      logic          tx;
      logic [DW-1:0] c2;
      logic [DW-1:0] c3;
      logic [DW-1:0] r;
      logic          e_ready;
      logic          e_head;
      logic          e_busy;
   } vec_t;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_rise = 0;
   int   n_under = 0;
   logic prev_head = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (head_flag && !prev_head)
         n_rise <= n_rise + 1;
      if (underrun)
         n_under <= n_under + 1;
      prev_head <= head_flag;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tx_en = 1'b0;
      in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic push(input trip_t t);
      in_valid = 1'b1;
      in_ch2 = t.c2;
      in_ch3 = t.c3;
      in_ref = t.r;
      tick();
      in_valid = 1'b0;
   endtask

   // Waits for a frame, checks data and high time; returns at the
   // first post-edge sample with head_flag low.
   task automatic frame(input string tag, input trip_t t,
                        input int drop_at, output int rise_at);
      int n;
      int len;
      n = 0;
      while (!head_flag && n < 300) begin
         tick();
         n++;
      end
      chk({tag, "_rise"}, 32'(head_flag), 32'd1);
      rise_at = cyc;
      chk({tag, "_b2"}, 32'(buffer_2), 32'(t.c2));
      chk({tag, "_b3"}, 32'(buffer_3), 32'(t.c3));
      chk({tag, "_reff"}, 32'(reff), 32'(t.r));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      len = 0;
      while (head_flag && len < 300) begin
         if (len == drop_at)
            tx_en = 1'b0;
         tick();
         len++;
      end
      chk({tag, "_len"}, 32'(len), 32'd52);
      chk({tag, "_b2_hold"}, 32'(buffer_2), 32'(t.c2));
      chk({tag, "_reff_hold"}, 32'(reff), 32'(t.r));
   endtask

   trip_t ftab [4];
   vec_t  vtab [7];
   int    rises [4];
   int    r0;
   int    u0;
   int    ra;
   int    n;

   initial begin
      ftab[0] = '{14'h0111, 14'h0222, 14'h0333};
      ftab[1] = '{14'h3FFF, 14'h0000, 14'h2AAA};
      ftab[2] = '{14'h1555, 14'h3ABC, 14'h0001};
      ftab[3] = '{14'h0F0F, 14'h30F0, 14'h3FFF};

      // Full-FIFO run: six pushes offered with tx_en=0, only four fit.
      vtab[0] = '{1'b1, 1'b0, 14'h0A01, 14'h0B01, 14'h0C01, 1'b1, 1'b0, 1'b0};
      vtab[1] = '{1'b1, 1'b0, 14'h0A02, 14'h0B02, 14'h0C02, 1'b1, 1'b0, 1'b0};
      vtab[2] = '{1'b1, 1'b0, 14'h0A03, 14'h0B03, 14'h0C03, 1'b1, 1'b0, 1'b0};
      vtab[3] = '{1'b1, 1'b0, 14'h0A04, 14'h0B04, 14'h0C04, 1'b0, 1'b0, 1'b0};
      vtab[4] = '{1'b1, 1'b0, 14'h0A05, 14'h0B05, 14'h0C05, 1'b0, 1'b0, 1'b0};
      vtab[5] = '{1'b1, 1'b0, 14'h0A06, 14'h0B06, 14'h0C06, 1'b0, 1'b0, 1'b0};
      vtab[6] = '{1'b0, 1'b0, 14'h0000, 14'h0000, 14'h0000, 1'b0, 1'b0, 1'b0};

      // Reset state
      repeat (3) tick();
      chk("rst_head", 32'(head_flag), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_b2", 32'(buffer_2), 32'd0);
      chk("rst_under", 32'(underrun), 32'd0);
      rst = 1'b0;
      tick();

      // 1: reset in the middle of a frame
      do_reset();
      tx_en = 1'b1;
      push(ftab[0]);
      push(ftab[1]);
      n = 0;
      while (!head_flag && n < 20) begin
         tick();
         n++;
      end
      chk("s1_rise", 32'(head_flag), 32'd1);
      repeat (5) tick();
      rst = 1'b1;
      tx_en = 1'b0;
      tick();
      chk("s1_abort", 32'(head_flag), 32'd0);
      tick();
      tick();
      chk("s1_b2", 32'(buffer_2), 32'd0);
      chk("s1_b3", 32'(buffer_3), 32'd0);
      chk("s1_reff", 32'(reff), 32'd0);
      chk("s1_ready", 32'(in_ready), 32'd1);
      chk("s1_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tx_en = 1'b1;
      r0 = n_rise;
      repeat (10) tick();
      chk("s1_fifo_lost", 32'(n_rise - r0), 32'd0);
      tx_en = 1'b0;

      // 2: single frame with two-edge latency
      do_reset();
      tx_en = 1'b1;
      u0 = n_under;
      push('{14'h0123, 14'h0456, 14'h0789});
      chk("s2_lat0", 32'(head_flag), 32'd0);
      tick();
      chk("s2_lat1", 32'(head_flag), 32'd1);
      frame("s2", '{14'h0123, 14'h0456, 14'h0789}, -1, ra);
      repeat (5) tick();
      chk("s2_b3_gap", 32'(buffer_3), 32'h0456);
      chk("s2_under", 32'(n_under - u0), 32'd1);
      chk("s2_idle", 32'(busy), 32'd0);
      tx_en = 1'b0;

      // 3: back-to-back frames
      do_reset();
      for (int i = 0; i < 4; i++)
         push(ftab[i]);
      r0 = n_rise;
      u0 = n_under;
      tx_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         frame($sformatf("s3_f%0d", i), ftab[i], -1, rises[i]);
         if (i < 3)
            chk($sformatf("s3_no_under%0d", i), 32'(n_under - u0), 32'd0);
      end
      for (int i = 1; i < 4; i++)
         chk($sformatf("s3_period%0d", i), 32'(rises[i] - rises[i-1]), 32'd57);
      repeat (8) tick();
      chk("s3_rises", 32'(n_rise - r0), 32'd4);
      chk("s3_under", 32'(n_under - u0), 32'd1);
`ifdef ALOG_TX_STATS_EN
      chk("s6_frame_cnt", 32'(frame_cnt), 32'd4);
      chk("s6_underrun_cnt", 32'(underrun_cnt), 32'd1);
`endif
      tx_en = 1'b0;

      // 4: full FIFO, table driven
      do_reset();
      for (int i = 0; i < 7; i++) begin
         in_valid = vtab[i].v;
         tx_en = vtab[i].tx;
         in_ch2 = vtab[i].c2;
         in_ch3 = vtab[i].c3;
         in_ref = vtab[i].r;
         tick();
         chk($sformatf("s4_ready%0d", i), 32'(in_ready), 32'(vtab[i].e_ready));
         chk($sformatf("s4_head%0d", i), 32'(head_flag), 32'(vtab[i].e_head));
         chk($sformatf("s4_busy%0d", i), 32'(busy), 32'(vtab[i].e_busy));
      end
      in_valid = 1'b0;
      r0 = n_rise;
      tx_en = 1'b1;
      for (int i = 0; i < 4; i++)
         frame($sformatf("s4_f%0d", i),
               '{vtab[i].c2, vtab[i].c3, vtab[i].r}, -1, ra);
      repeat (80) tick();
      chk("s4_rises", 32'(n_rise - r0), 32'd4);
      chk("s4_ready_end", 32'(in_ready), 32'd1);
      tx_en = 1'b0;

      // 5: tx_en dropped mid-frame
      do_reset();
      push(ftab[2]);
      push(ftab[3]);
      r0 = n_rise;
      u0 = n_under;
      tx_en = 1'b1;
      frame("s5", ftab[2], 10, ra);
      repeat (100) tick();
      chk("s5_rises", 32'(n_rise - r0), 32'd1);
      chk("s5_under", 32'(n_under - u0), 32'd0);
      chk("s5_busy", 32'(busy), 32'd0);
      chk("s5_ready", 32'(in_ready), 32'd1);
      tx_en = 1'b1;
      frame("s5_kept", ftab[3], -1, ra);
      tx_en = 1'b0;
      repeat (10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
